sign_compressor: RTL and testbench
==================================

SIGN_COMPRESSOR -- requirements
Module: sign_compressor

Interface
REQ-001 SHALL have parameter: IN_W, 32, input word width.
REQ-002 SHALL have parameter: OUT_W, 17, output signed field width (the immediate width used by the datapath).
REQ-003 SHALL have parameter: CNT_W, 8, overflow event counter width.
REQ-004 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: in_valid  input  1  producer presents a word.
REQ-007 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port: in_data  input  IN_W  two's-complement value to compress.
REQ-009 SHALL have port: sat_en  input  1  1 = saturate on overflow, 0 = wrap (truncate).
REQ-010 SHALL have port: out_valid  output  1  output word available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the word this cycle.
REQ-012 SHALL have port: out_data  output  OUT_W  compressed value.
REQ-013 SHALL have port: out_ovf  output  1  input was not representable in OUT_W bits signed.
REQ-014 SHALL have port: clr_count  input  1  synchronous clear of ovf_count.
REQ-015 SHALL have port: ovf_count  output  CNT_W  number of accepted overflowing words, saturating.

Function
REQ-016 SHALL accept a word when in_valid and in_ready are both 1 in the same cycle; SHALL pop when out_valid and out_ready are both 1.
REQ-017 SHALL buffer results in a 2-entry FIFO; in_ready = not full, registered, with no combinational path from out_ready.
REQ-018 SHALL declare fit when in_data[IN_W-1:OUT_W-1] are all equal; out_ovf = not fit.
REQ-019 SHALL, when fit, produce out_data = in_data[OUT_W-1:0] regardless of sat_en.
REQ-020 SHALL, when not fit and sat_en=0, produce out_data = in_data[OUT_W-1:0].
REQ-021 SHALL, when not fit and sat_en=1, produce 0x10000 if in_data[IN_W-1]=1, else 0x0FFFF.
REQ-022 SHALL sample sat_en with in_data at acceptance; later changes do not affect stored entries.
REQ-023 SHALL present an accepted word on out_valid exactly one cycle after acceptance when FIFO was empty (latency 1).
REQ-024 SHALL hold out_data/out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL keep occupancy unchanged on simultaneous push and pop; order strictly FIFO.
REQ-026 SHALL increment ovf_count by 1 on each accepted non-fitting word, holding at all-ones.
REQ-027 SHALL give clr_count priority over increment in the same cycle (result 0).

Reset
REQ-028 SHALL on reset_n=0 immediately force: FIFO empty, out_valid=0, in_ready=0, out_data=0, out_ovf=0, ovf_count=0.
REQ-029 SHALL raise in_ready on the first clock edge after reset_n deasserts; words in flight at reset are discarded.

Structure
REQ-030 SHALL place IN_W/OUT_W defaults and saturation constants (SAT_POS=0x0FFFF, SAT_NEG=0x10000) in shared package sign_compressor_pkg.
REQ-031 SHALL implement buffering in one sub-module skid_fifo2 (2-deep, width OUT_W+1); compress logic stays in the top.

Verification
REQ-032 SHALL test fit cases: 0x0000FFFF -> 0x0FFFF ovf=0; 0xFFFF0000 -> 0x10000 ovf=0, latency 1.
REQ-033 SHALL test overflow: 0x00010000 sat_en=1 -> 0x0FFFF ovf=1; sat_en=0 -> 0x10000 ovf=1; 0x80000000 sat_en=1 -> 0x10000, sat_en=0 -> 0x00000.
REQ-034 SHALL test backpressure: out_ready=0, push 3 words -> in_ready=0 after 2, third held; release -> all 3 out in order.
REQ-035 SHALL test counter: 300 overflowing words with CNT_W=8 -> ovf_count=255; clr_count with an overflowing accept same cycle -> 0.
REQ-036 SHALL test reset mid-stream: reset_n low with 2 entries stored -> out_valid=0, ovf_count=0 immediately; no stale word after release.

Source files
------------

// File: rtl/sign_compressor_pkg.sv
// Shared constants for the sign compressor: default widths and saturation values.
package sign_compressor_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 17;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [OUT_W_DEF-1:0] SAT_POS = 17'h0FFFF;
  localparam logic [OUT_W_DEF-1:0] SAT_NEG = 17'h10000;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a registered ready; no combinational path from out_ready_i to in_ready_o.
module skid_fifo2 #(
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             ready_q;
  logic             push, pop;

  assign push        = in_valid_i & ready_q;
  assign out_valid_o = (cnt_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ready_q stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/sign_compressor.sv
// Compresses a two's-complement word to OUT_W bits (wrap or saturate), flags overflow,
// buffers results in a 2-entry FIFO and counts overflowing words.
module sign_compressor
  import sign_compressor_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [OUT_W-1:0] SatPos =
      (OUT_W == OUT_W_DEF) ? OUT_W'(SAT_POS) : {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SatNeg =
      (OUT_W == OUT_W_DEF) ? OUT_W'(SAT_NEG) : {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] upper;
  logic                fit;
  logic                accept;
  logic [OUT_W-1:0]    comp_data;
  logic [OUT_W:0]      fifo_out;
  logic [CNT_W-1:0]    ovf_count_q;

  // Representable iff the sign bit of the result and everything above agree.
  assign upper  = in_data[IN_W-1:OUT_W-1];
  assign fit    = (&upper) | ~(|upper);
  assign accept = in_valid & in_ready;

  always_comb begin
    comp_data = in_data[OUT_W-1:0];
    if (!fit && sat_en) begin
      comp_data = in_data[IN_W-1] ? SatNeg : SatPos;
    end
  end

  skid_fifo2 #(
    .Width(OUT_W + 1)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  ({~fit, comp_data}),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (fifo_out)
  );

  assign out_ovf  = fifo_out[OUT_W];
  assign out_data = fifo_out[OUT_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count_q <= '0;
    end else if (clr_count) begin
      ovf_count_q <= '0;
    end else if (accept && !fit && !(&ovf_count_q)) begin
      ovf_count_q <= ovf_count_q + CNT_W'(1);
    end
  end

  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_sign_compressor.sv
// Directed self-checking bench for sign_compressor.
module tb_sign_compressor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_ovf;
  logic        clr_count;
  logic [7:0]  ovf_count;

  int vectors = 0;
  int miscompares = 0;

  sign_compressor #(
    .IN_W (32),
    .OUT_W(17),
    .CNT_W(8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sat_en   (sat_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .clr_count(clr_count),
    .ovf_count(ovf_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one word into an empty FIFO with out_ready=1 and check latency-1 output.
  task automatic push_one(input string tag, input logic [31:0] d, input logic s,
                          input logic [16:0] exp_d, input logic exp_o);
    in_valid = 1'b1;
    in_data  = d;
    sat_en   = s;
    chk({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
    step();
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sat_en    = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // Fit and overflow vectors
    push_one("fit_pos", 32'h0000FFFF, 1'b1, 17'h0FFFF, 1'b0);
    push_one("fit_neg", 32'hFFFF0000, 1'b0, 17'h10000, 1'b0);
    push_one("ovf_pos_sat", 32'h00010000, 1'b1, 17'h0FFFF, 1'b1);
    push_one("ovf_pos_wrap", 32'h00010000, 1'b0, 17'h10000, 1'b1);
    push_one("ovf_neg_sat", 32'h80000000, 1'b1, 17'h10000, 1'b1);
    push_one("ovf_neg_wrap", 32'h80000000, 1'b0, 17'h00000, 1'b1);
    chk("count_after_4", 32'(ovf_count), 32'd4);

    // sat_en is captured at acceptance; output held while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00010000;
    sat_en    = 1'b1;
    step();
    in_valid = 1'b0;
    sat_en   = 1'b0;
    chk("hold_data0", 32'(out_data), 32'h0FFFF);
    step();
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data1", 32'(out_data), 32'h0FFFF);
    chk("hold_ovf", 32'(out_ovf), 32'd1);
    out_ready = 1'b1;
    step();
    chk("hold_drained", 32'(out_valid), 32'd0);
    chk("count_after_5", 32'(ovf_count), 32'd5);

    // Backpressure: three words, only two fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd1;
    chk("bp_ready_a", 32'(in_ready), 32'd1);
    step();
    in_data = 32'd2;
    chk("bp_ready_b", 32'(in_ready), 32'd1);
    step();
    in_data = 32'd3;
    chk("bp_full", 32'(in_ready), 32'd0);
    step();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_head_a", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", 32'(out_data), 32'd2);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_c", 32'(out_data), 32'd3);
    chk("bp_out_c_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Counter saturation and clear priority
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    chk("cnt_cleared", 32'(ovf_count), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h00010000;
    for (int i = 0; i < 300; i++) step();
    chk("cnt_saturated", 32'(ovf_count), 32'd255);
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    chk("cnt_clr_priority", 32'(ovf_count), 32'd0);
    step();
    in_valid = 1'b0;
    chk("cnt_incr_after_clr", 32'(ovf_count), 32'd1);
    step();
    chk("cnt_drained", 32'(out_valid), 32'd0);

    // Reset with two stored entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00010000;
    step();
    in_data = 32'h00000005;
    step();
    in_valid = 1'b0;
    chk("mid_full", 32'(in_ready), 32'd0);
    chk("mid_count", 32'(ovf_count), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(ovf_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    chk("mid_rel_valid", 32'(out_valid), 32'd0);
    step();
    chk("mid_no_stale", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
